// File: rtl/mul_seq.sv
// ============================================================================
//  Module      : mul_seq
//  Description : Multicycle sequencer around a 32x32 signed multiplier; owns
//                HI/LO, MTHI/MTLO writes, busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_prod,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        signed_q, signed_d;
    logic        done_q, done_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] result;

    // Unsigned product = signed product plus the sign-bit weight of each operand.
    always_comb begin
        result = mul_prod;
        if (!signed_q) begin
            if (mul_a_q[31]) result = result + {mul_b_q, 32'b0};
            if (mul_b_q[31]) result = result + {mul_a_q, 32'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && !flush) begin
                    mul_a_d  = op_a;
                    mul_b_d  = op_b;
                    signed_d = is_signed;
                    count_d  = COUNT_INIT;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
            mul_a_q  <= 32'd0;
            mul_b_q  <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            signed_q <= signed_d;
            done_q   <= done_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Directed self-checking bench for mul_seq (LATENCY=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_prod;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic signed [63:0] a64, b64;

    int total = 0;
    int bad   = 0;

    // Combinational signed multiplier the sequencer drives.
    assign a64      = {{32{mul_a[31]}}, mul_a};
    assign b64      = {{32{mul_b[31]}}, mul_b};
    assign mul_prod = a64 * b64;

    always #5 clk = ~clk;

    mul_seq #(.LATENCY(LATENCY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply, check busy for LATENCY cycles, leave bench in done cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; is_signed = s; op_a = a; op_b = b;
        tick();
        start = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_nodone"}, 64'(done), 64'd0);
            tick();
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mul",  {mul_a, mul_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1 then back-to-back unsigned issue in the done cycle
        run_op("t1", 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
        start = 1'b1; is_signed = 1'b0; op_a = 32'h10000; op_b = 32'h10000;
        tick();
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_pulse", 64'(done), 64'd0);
        // Test 4: start + mthi while busy are ignored
        start = 1'b1; is_signed = 1'b1; op_a = 32'd5; op_b = 32'd5;
        mthi = 1'b1; wdata = 32'h1234;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_hi_hold", 64'(hi), 64'hFFFFFFFF);
        tick();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_hilo", {hi, lo}, 64'h00000001_00000000);
        chk("t4_mula", 64'(mul_a), 64'h10000);
        tick();
        chk("t4_nostart", 64'(busy), 64'd0);
        chk("t4_done1", 64'(done), 64'd0);

        // Test 2
        run_op("t2u", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        tick();
        run_op("t2s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
        tick();
        run_op("t2m", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
        chk("hold_mulb", 64'(mul_b), 64'h80000000);
        tick();

        // Test 5: flush
        mthi = 1'b1; wdata = 32'hAAAA;
        tick();
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5555;
        tick();
        mtlo = 1'b0;
        chk("t5_pre", {hi, lo}, 64'h0000AAAA_00005555);
        start = 1'b1; is_signed = 1'b1; op_a = 32'd2; op_b = 32'd3;
        tick();
        start = 1'b0; flush = 1'b1;
        chk("t5_run", 64'(busy), 64'd1);
        tick();
        flush = 1'b0;
        chk("t5_fl_busy", 64'(busy), 64'd0);
        chk("t5_fl_done", 64'(done), 64'd0);
        tick();
        chk("t5_fl_done2", 64'(done), 64'd0);
        chk("t5_hilo", {hi, lo}, 64'h0000AAAA_00005555);
        flush = 1'b1; start = 1'b1; mthi = 1'b1; wdata = 32'hBBBB;
        tick();
        flush = 1'b0; start = 1'b0; mthi = 1'b0;
        chk("t5_idle_fl", 64'(busy), 64'd0);
        chk("t5_fl_mthi", 64'(hi), 64'hBBBB);

        // Test 6: asynchronous reset mid-RUN
        start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
        tick();
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_hilo", {hi, lo}, 64'd0);
        chk("t6_mul", {mul_a, mul_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_nodone", 64'(done), 64'd0);
        // Start with simultaneous mthi: write lands now, result overwrites later
        mthi = 1'b1; wdata = 32'h77;
        start = 1'b1; is_signed = 1'b0; op_a = 32'd6; op_b = 32'd7;
        tick();
        mthi = 1'b0; start = 1'b0;
        chk("t6_mthi_now", 64'(hi), 64'h77);
        tick();
        tick();
        chk("t6_done2", 64'(done), 64'd1);
        chk("t6_hilo2", {hi, lo}, 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multicycle sequencer for the CPU's 32x32 combinational signed multiplier.
- Accepts MULT/MULTU issue from the execute stage and latches the operands.
- Drives the multiplier from registered operands so its path may span LATENCY cycles.
- Applies the unsigned correction, owns the architectural HI/LO registers, and provides the busy/stall and completion handshake. MTHI/MTLO writes are also handled here.

Parameters:
LATENCY, 2, cycles allowed for the multiplier path (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  issue multiply this cycle
is_signed  in  1  1=MULT (signed), 0=MULTU; sampled with start
op_a  in  32  operand A; sampled with start
op_b  in  32  operand B; sampled with start
flush  in  1  abort any in-flight multiply
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  32  MTHI/MTLO data
mul_a  out  32  to multiplier input a (registered)
mul_b  out  32  to multiplier input b (registered)
mul_prod  in  64  signed product from the multiplier
busy  out  1  multiply in flight; pipeline stalls HI/LO readers and new mul ops
done  out  1  one-cycle pulse, HI/LO updated
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, count=0.
  - busy=0, done=0, hi=0, lo=0, mul_a=0, mul_b=0, sign flag=0.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE and RUN. done is a registered flag, not a state.
- IDLE, start=1, flush=0:
  - At the edge: mul_a<=op_a, mul_b<=op_b, latch is_signed, count<=LATENCY-1, go to RUN.
  - busy=1 from the next cycle.
- RUN with count>0: count decrements each edge.
- RUN with count==0, at the edge:
  - Capture {hi,lo} from the corrected product.
  - done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge k; HI/LO valid and done=1 after edge k+LATENCY; busy is high for exactly LATENCY cycles.
- Product correction (all arithmetic mod 2^64):
  - Signed: result = mul_prod.
  - Unsigned: result = mul_prod + (mul_a[31] ? {mul_b,32'b0} : 0) + (mul_b[31] ? {mul_a,32'b0} : 0).
- done is high for exactly one cycle, and is 0 in every cycle where busy=1.
- start:
  - Accepted in the done cycle (back-to-back issue, no bubble).
  - start while busy=1 is ignored. The pipeline must not issue while busy; the bench checks the ignore.
- flush:
  - In RUN: go to IDLE at the edge, busy<=0, no done, HI/LO unchanged.
  - In IDLE: suppresses a simultaneous start.
  - Has no effect on mthi/mtlo.
- mthi/mtlo:
  - Accepted only when busy=0: hi<=wdata / lo<=wdata at the edge. Both may be asserted together.
  - Ignored while busy=1.
  - Simultaneous with an accepted start: the write occurs now, and the multiply result overwrites HI/LO at completion.
- mul_a/mul_b hold their values after completion until the next accepted start.

Test Plan:
1. LATENCY=2, signed, a=0xFFFFFFFD (-3), b=7 -> busy high 2 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. a=b=0xFFFFFFFF:
   - Unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
   - Signed -> hi=0x00000000, lo=0x00000001.
   - Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. Back-to-back: second start (unsigned 0x10000*0x10000) asserted in the done cycle of test 1 -> accepted with no gap; hi=0x00000001, lo=0.
4. start and mthi with wdata=0x1234 asserted while busy -> both ignored; result equals first operation; hi!=0x1234.
5. flush in the first RUN cycle with prior hi=0xAAAA, lo=0x5555 -> busy drops next edge, no done, hi/lo keep 0xAAAA/0x5555. flush+start in IDLE -> busy stays 0.
6. rst_n low mid-RUN, between edges -> busy, done, hi, lo, mul_a, mul_b go to 0 immediately; after release, a fresh start with 6*7 gives lo=42, hi=0.
